// File: rtl/ysyx_22050019_axi_lite_dmem_pkg.sv
// Shared definitions for the AXI4-Lite data-memory responder: response codes,
// controller states and the address-window check.
package ysyx_22050019_axi_lite_dmem_pkg;

  localparam logic [1:0]  RespOkay        = 2'b00;
  localparam logic [1:0]  RespSlverr      = 2'b10;
  localparam logic [63:0] DefaultAddrBase = 64'h8000_0000;
  localparam int unsigned StrbW           = 8;

  typedef enum logic [2:0] {
    StIdle,
    StRdWait,
    StRdResp,
    StWrWait,
    StWrResp
  } dmem_state_e;

  // True when addr falls inside the 2**depth_log2-word window starting at base.
  function automatic logic addr_in_range(input logic [63:0] addr, input logic [63:0] base,
                                         input int unsigned depth_log2);
    logic [63:0] off;
    off = addr - base;
    return (addr >= base) && ((off >> (depth_log2 + 32'd3)) == 64'd0);
  endfunction

endpackage

// File: rtl/ysyx_22050019_dmem_array.sv
// Word-addressed 64-bit storage with byte-strobed synchronous write and an
// asynchronous read port. Contents are intentionally not reset.
module ysyx_22050019_dmem_array
  import ysyx_22050019_axi_lite_dmem_pkg::*;
#(
  parameter int unsigned DepthLog2 = 12
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [DepthLog2-1:0] widx_i,
  input  logic [63:0]          wdata_i,
  input  logic [StrbW-1:0]     wstrb_i,
  input  logic [DepthLog2-1:0] ridx_i,
  output logic [63:0]          rdata_o
);

  localparam int unsigned Depth = 1 << DepthLog2;

  logic [63:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int i = 0; i < StrbW; i++) begin
        if (wstrb_i[i]) begin
          mem_q[widx_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end
    end
  end

  assign rdata_o = mem_q[ridx_i];

endmodule

// File: rtl/ysyx_22050019_axi_lite_dmem.sv
// AXI4-Lite responder for LSU loads/stores: one transaction in flight, fixed
// response latency, round-robin arbitration between read and write requests.
module ysyx_22050019_axi_lite_dmem
  import ysyx_22050019_axi_lite_dmem_pkg::*;
#(
  parameter logic [63:0] ADDR_BASE  = DefaultAddrBase,
  parameter int unsigned DEPTH_LOG2 = 12,
  parameter int unsigned LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] s_axi_araddr,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [63:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  input  logic [63:0] s_axi_awaddr,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [63:0] s_axi_wdata,
  input  logic [7:0]  s_axi_wstrb,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready
);

  typedef logic [DEPTH_LOG2-1:0] idx_t;

  localparam int unsigned CntInitI = (LATENCY == 0) ? 0 : LATENCY - 1;
  localparam logic [3:0]  CntInit  = CntInitI[3:0];

  dmem_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  idx_t        idx_q, idx_d;
  logic        err_q, err_d;
  logic [63:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;
  logic [1:0]  bresp_q, bresp_d;
  logic        lww_q, lww_d;

  idx_t        ar_idx, aw_idx, rd_idx;
  logic        ar_in_range, aw_in_range, rd_err;
  logic        wr_grant, rd_grant;
  logic        mem_we, load_rdata;
  logic [63:0] mem_rdata;

  assign ar_idx      = idx_t'((s_axi_araddr - ADDR_BASE) >> 3);
  assign aw_idx      = idx_t'((s_axi_awaddr - ADDR_BASE) >> 3);
  assign ar_in_range = addr_in_range(s_axi_araddr, ADDR_BASE, DEPTH_LOG2);
  assign aw_in_range = addr_in_range(s_axi_awaddr, ADDR_BASE, DEPTH_LOG2);

  // Write needs AW and W together; on a conflict the channel not served last wins.
  assign wr_grant = s_axi_awvalid && s_axi_wvalid && (!s_axi_arvalid || !lww_q);
  assign rd_grant = s_axi_arvalid && !wr_grant;

  // With zero latency the word is fetched on the address handshake itself.
  assign rd_idx = (state_q == StIdle) ? ar_idx : idx_q;
  assign rd_err = (state_q == StIdle) ? !ar_in_range : err_q;

  ysyx_22050019_dmem_array #(
    .DepthLog2 (DEPTH_LOG2)
  ) u_array (
    .clk_i   (clk),
    .we_i    (mem_we),
    .widx_i  (aw_idx),
    .wdata_i (s_axi_wdata),
    .wstrb_i (s_axi_wstrb),
    .ridx_i  (rd_idx),
    .rdata_o (mem_rdata)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    err_d         = err_q;
    rdata_d       = rdata_q;
    rresp_d       = rresp_q;
    bresp_d       = bresp_q;
    lww_d         = lww_q;
    s_axi_arready = 1'b0;
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    mem_we        = 1'b0;
    load_rdata    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (wr_grant) begin
          s_axi_awready = 1'b1;
          s_axi_wready  = 1'b1;
          mem_we        = aw_in_range;
          bresp_d       = aw_in_range ? RespOkay : RespSlverr;
          lww_d         = 1'b1;
          cnt_d         = CntInit;
          state_d       = (LATENCY == 0) ? StWrResp : StWrWait;
        end else if (rd_grant) begin
          s_axi_arready = 1'b1;
          idx_d         = ar_idx;
          err_d         = !ar_in_range;
          lww_d         = 1'b0;
          cnt_d         = CntInit;
          if (LATENCY == 0) begin
            state_d    = StRdResp;
            load_rdata = 1'b1;
          end else begin
            state_d = StRdWait;
          end
        end
      end
      StRdWait: begin
        if (cnt_q == 4'd0) begin
          state_d    = StRdResp;
          load_rdata = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StRdResp: begin
        if (s_axi_rready) state_d = StIdle;
      end
      StWrWait: begin
        if (cnt_q == 4'd0) begin
          state_d = StWrResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StWrResp: begin
        if (s_axi_bready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (load_rdata) begin
      rdata_d = rd_err ? 64'd0 : mem_rdata;
      rresp_d = rd_err ? RespSlverr : RespOkay;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= 64'd0;
      rresp_q <= RespOkay;
      bresp_q <= RespOkay;
      lww_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      rresp_q <= rresp_d;
      bresp_q <= bresp_d;
      lww_q   <= lww_d;
    end
  end

  assign s_axi_rvalid = (state_q == StRdResp);
  assign s_axi_bvalid = (state_q == StWrResp);
  assign s_axi_rdata  = rdata_q;
  assign s_axi_rresp  = rresp_q;
  assign s_axi_bresp  = bresp_q;

endmodule

// File: tb/tb_ysyx_22050019_axi_lite_dmem.sv
// Bench for the AXI4-Lite data memory: directed vector table, stall/reset/arbitration
// sequences, and random traffic checked against a byte-addressed memory model.
module tb_ysyx_22050019_axi_lite_dmem;

  localparam logic [63:0] Base      = 64'h8000_0000;
  localparam int unsigned DepthLog2 = 12;
  localparam int unsigned Latency   = 2;
  localparam int          Timeout   = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] s_axi_araddr = '0;
  logic        s_axi_arvalid = 1'b0;
  logic        s_axi_arready;
  logic [63:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready = 1'b1;
  logic [63:0] s_axi_awaddr = '0;
  logic        s_axi_awvalid = 1'b0;
  logic        s_axi_awready;
  logic [63:0] s_axi_wdata = '0;
  logic [7:0]  s_axi_wstrb = '0;
  logic        s_axi_wvalid = 1'b0;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ysyx_22050019_axi_lite_dmem #(
    .ADDR_BASE  (Base),
    .DEPTH_LOG2 (DepthLog2),
    .LATENCY    (Latency)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axi_araddr  (s_axi_araddr),
    .s_axi_arvalid (s_axi_arvalid),
    .s_axi_arready (s_axi_arready),
    .s_axi_rdata   (s_axi_rdata),
    .s_axi_rresp   (s_axi_rresp),
    .s_axi_rvalid  (s_axi_rvalid),
    .s_axi_rready  (s_axi_rready),
    .s_axi_awaddr  (s_axi_awaddr),
    .s_axi_awvalid (s_axi_awvalid),
    .s_axi_awready (s_axi_awready),
    .s_axi_wdata   (s_axi_wdata),
    .s_axi_wstrb   (s_axi_wstrb),
    .s_axi_wvalid  (s_axi_wvalid),
    .s_axi_wready  (s_axi_wready),
    .s_axi_bresp   (s_axi_bresp),
    .s_axi_bvalid  (s_axi_bvalid),
    .s_axi_bready  (s_axi_bready)
  );

  // Reference model: plain byte-addressed storage inside the legal window.
  logic [7:0] mem_m [longint unsigned];

  function automatic bit in_range_m(input logic [63:0] a);
    return (a >= Base) && (a < Base + (64'd8 << DepthLog2));
  endfunction

  function automatic void model_write(input logic [63:0] a, input logic [63:0] d,
                                      input logic [7:0] s);
    logic [63:0] word_addr;
    word_addr = a & ~64'd7;
    if (in_range_m(a)) begin
      for (int i = 0; i < 8; i++) begin
        if (s[i]) mem_m[word_addr + 64'(i)] = d[8*i +: 8];
      end
    end
  endfunction

  function automatic logic [63:0] model_read(input logic [63:0] a);
    logic [63:0] word_addr;
    logic [63:0] r;
    word_addr = a & ~64'd7;
    r = '0;
    if (in_range_m(a)) begin
      for (int i = 0; i < 8; i++) begin
        r[8*i +: 8] = mem_m.exists(word_addr + 64'(i)) ? mem_m[word_addr + 64'(i)] : 8'hxx;
      end
    end
    return r;
  endfunction

  function automatic logic [1:0] model_resp(input logic [63:0] a);
    return in_range_m(a) ? 2'b00 : 2'b10;
  endfunction

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out", name);
  endtask

  // Called at a negedge; returns one cycle after the B handshake.
  task automatic axi_write(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s,
                           output logic [1:0] resp, output int lat);
    int n;
    s_axi_awaddr  = a;
    s_axi_wdata   = d;
    s_axi_wstrb   = s;
    s_axi_awvalid = 1'b1;
    s_axi_wvalid  = 1'b1;
    s_axi_bready  = 1'b1;
    #1;
    n = 0;
    while (!(s_axi_awready && s_axi_wready) && n < Timeout) begin
      @(negedge clk);
      n++;
    end
    resp = 2'b11;
    lat  = -1;
    if (n >= Timeout) begin
      fail_now("write address handshake");
      s_axi_awvalid = 1'b0;
      s_axi_wvalid  = 1'b0;
      return;
    end
    @(negedge clk);
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
    n = 0;
    while (!s_axi_bvalid && n < Timeout) begin
      @(negedge clk);
      n++;
    end
    if (n >= Timeout) begin
      fail_now("write response");
      return;
    end
    lat  = n;
    resp = s_axi_bresp;
    @(negedge clk);
  endtask

  // Called at a negedge; rready held low for 'stall' cycles after rvalid rises.
  task automatic axi_read(input logic [63:0] a, input int stall, output logic [63:0] data,
                          output logic [1:0] resp, output int lat);
    int n;
    s_axi_araddr  = a;
    s_axi_arvalid = 1'b1;
    s_axi_rready  = (stall == 0);
    #1;
    n = 0;
    while (!s_axi_arready && n < Timeout) begin
      @(negedge clk);
      n++;
    end
    data = 'x;
    resp = 2'b11;
    lat  = -1;
    if (n >= Timeout) begin
      fail_now("read address handshake");
      s_axi_arvalid = 1'b0;
      s_axi_rready  = 1'b1;
      return;
    end
    @(negedge clk);
    s_axi_arvalid = 1'b0;
    n = 0;
    while (!s_axi_rvalid && n < Timeout) begin
      @(negedge clk);
      n++;
    end
    if (n >= Timeout) begin
      fail_now("read response");
      s_axi_rready = 1'b1;
      return;
    end
    lat  = n;
    data = s_axi_rdata;
    resp = s_axi_rresp;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      s_axi_arvalid = 1'b1;
      #1;
      check64("stall rvalid", 64'(s_axi_rvalid), 64'd1);
      check64("stall rdata", s_axi_rdata, data);
      check64("stall rresp", 64'(s_axi_rresp), 64'(resp));
      check64("stall arready", 64'(s_axi_arready), 64'd0);
    end
    s_axi_arvalid = 1'b0;
    s_axi_rready  = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check64({tag, " arready"}, 64'(s_axi_arready), 64'd0);
    check64({tag, " awready"}, 64'(s_axi_awready), 64'd0);
    check64({tag, " wready"}, 64'(s_axi_wready), 64'd0);
    check64({tag, " rvalid"}, 64'(s_axi_rvalid), 64'd0);
    check64({tag, " bvalid"}, 64'(s_axi_bvalid), 64'd0);
    check64({tag, " rdata"}, s_axi_rdata, 64'd0);
    check64({tag, " rresp"}, 64'(s_axi_rresp), 64'd0);
    check64({tag, " bresp"}, 64'(s_axi_bresp), 64'd0);
  endtask

  typedef struct {
    bit          wr;
    logic [63:0] addr;
    logic [63:0] data;
    logic [7:0]  strb;
    logic [1:0]  resp;
    logic [63:0] rdata;
  } vec_t;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[$];
    logic [63:0] data, exp_d, a;
    logic [1:0]  resp;
    int          lat, n;
    bit          grants[$];
    logic [63:0] pool[8];

    vecs.push_back('{1'b1, 64'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF, 2'b00, 64'h0});
    vecs.push_back('{1'b0, 64'h8000_0010, 64'h0, 8'h00, 2'b00, 64'h1122_3344_5566_7788});
    vecs.push_back('{1'b1, 64'h8000_0010, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F, 2'b00, 64'h0});
    vecs.push_back('{1'b0, 64'h8000_0017, 64'h0, 8'h00, 2'b00, 64'h1122_3344_AAAA_AAAA});
    vecs.push_back('{1'b1, 64'h8000_0000, 64'h5555_6666_7777_8888, 8'hFF, 2'b00, 64'h0});
    vecs.push_back('{1'b1, 64'h8000_8000, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, 2'b10, 64'h0});
    vecs.push_back('{1'b0, 64'h8000_0000, 64'h0, 8'h00, 2'b00, 64'h5555_6666_7777_8888});
    vecs.push_back('{1'b1, 64'h8000_7FF8, 64'h0123_4567_89AB_CDEF, 8'hFF, 2'b00, 64'h0});
    vecs.push_back('{1'b0, 64'h8000_7FF8, 64'h0, 8'h00, 2'b00, 64'h0123_4567_89AB_CDEF});
    vecs.push_back('{1'b0, 64'h7FFF_FFF8, 64'h0, 8'h00, 2'b10, 64'h0});
    vecs.push_back('{1'b0, 64'h8000_8000, 64'h0, 8'h00, 2'b10, 64'h0});
    vecs.push_back('{1'b1, 64'h8000_0010, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 2'b00, 64'h0});
    vecs.push_back('{1'b1, 64'h8000_0010, 64'hFFFF_FFFF_FFFF_FFFF, 8'h80, 2'b00, 64'h0});
    vecs.push_back('{1'b0, 64'h8000_0010, 64'h0, 8'h00, 2'b00, 64'hFF22_3344_AAAA_AAAA});

    // Reset values
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Directed table
    foreach (vecs[i]) begin
      if (vecs[i].wr) begin
        axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp, lat);
        model_write(vecs[i].addr, vecs[i].data, vecs[i].strb);
        check64($sformatf("vec%0d bresp", i), 64'(resp), 64'(vecs[i].resp));
      end else begin
        axi_read(vecs[i].addr, 0, data, resp, lat);
        check64($sformatf("vec%0d rdata", i), data, vecs[i].rdata);
        check64($sformatf("vec%0d rresp", i), 64'(resp), 64'(vecs[i].resp));
      end
      check64($sformatf("vec%0d latency", i), 64'(lat), 64'(Latency));
    end

    // Response held while rready is low; no new request accepted meanwhile
    axi_read(64'h8000_0000, 5, data, resp, lat);
    check64("stalled read data", data, 64'h5555_6666_7777_8888);
    check64("stalled read resp", 64'(resp), 64'd0);

    // Random traffic against the model
    for (int k = 0; k < 8; k++) begin
      pool[k] = Base + 64'h100 + 64'(8 * k);
      data = {$urandom(), $urandom()};
      axi_write(pool[k], data, 8'hFF, resp, lat);
      model_write(pool[k], data, 8'hFF);
    end
    for (int k = 0; k < 120; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        a = $urandom_range(0, 1) ? Base - 64'(8 * (1 + $urandom_range(0, 15)))
                                 : Base + (64'd8 << DepthLog2) + 64'($urandom_range(0, 255));
      end else begin
        a = pool[$urandom_range(0, 7)] + 64'($urandom_range(0, 7));
      end
      if ($urandom_range(0, 1) == 1) begin
        data = {$urandom(), $urandom()};
        exp_d = 64'($urandom_range(0, 255));
        axi_write(a, data, exp_d[7:0], resp, lat);
        model_write(a, data, exp_d[7:0]);
        check64($sformatf("rand%0d bresp", k), 64'(resp), 64'(model_resp(a)));
      end else begin
        axi_read(a, 0, data, resp, lat);
        check64($sformatf("rand%0d rdata", k), data, model_read(a));
        check64($sformatf("rand%0d rresp", k), 64'(resp), 64'(model_resp(a)));
      end
      check64($sformatf("rand%0d latency", k), 64'(lat), 64'(Latency));
    end

    // Reset while a read is waiting: response must be dropped
    s_axi_araddr  = pool[3];
    s_axi_arvalid = 1'b1;
    s_axi_rready  = 1'b1;
    #1;
    n = 0;
    while (!s_axi_arready && n < Timeout) begin
      @(negedge clk);
      n++;
    end
    if (n >= Timeout) fail_now("reset-test address handshake");
    @(negedge clk);
    s_axi_arvalid = 1'b0;
    rst = 1'b1;
    #1;
    check_reset_outputs("mid reset");
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check64("post reset rvalid", 64'(s_axi_rvalid), 64'd0);
    end
    check_reset_outputs("post reset");
    axi_read(pool[3], 0, data, resp, lat);
    check64("post reset read data", data, model_read(pool[3]));
    check64("post reset read resp", 64'(resp), 64'd0);

    // Arbitration from reset with all requests held
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    s_axi_awaddr  = Base + 64'h200;
    s_axi_wdata   = 64'hCAFE_F00D_1234_5678;
    s_axi_wstrb   = 8'hFF;
    s_axi_araddr  = pool[0];
    s_axi_awvalid = 1'b1;
    s_axi_wvalid  = 1'b1;
    s_axi_arvalid = 1'b1;
    s_axi_rready  = 1'b1;
    s_axi_bready  = 1'b1;
    model_write(Base + 64'h200, 64'hCAFE_F00D_1234_5678, 8'hFF);
    #1;
    n = 0;
    while (grants.size() < 4 && n < 60) begin
      if (s_axi_awready && s_axi_arready) begin
        check64("dual grant", 64'd1, 64'd0);
      end
      if (s_axi_awready && s_axi_wready) grants.push_back(1'b1);
      else if (s_axi_arready) grants.push_back(1'b0);
      @(negedge clk);
      #1;
      n++;
    end
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
    s_axi_arvalid = 1'b0;
    check64("grant count", 64'(grants.size()), 64'd4);
    for (int k = 0; k < 4; k++) begin
      check64($sformatf("grant%0d is write", k),
              (k < grants.size()) ? 64'(grants[k]) : 64'hF, 64'((k % 2) == 0));
    end
    repeat (Latency + 4) @(negedge clk);
    axi_read(Base + 64'h200, 0, data, resp, lat);
    check64("arb write committed", data, model_read(Base + 64'h200));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
